// File: rtl/player_ctl.sv
// Per-frame player motion controller: horizontal direction FSM and
// vertical jump FSM, both updated once per vblank rising edge.
package state_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } State;
endpackage

module player_ctl
  import state_pkg::*;
#(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 984,
  parameter int X_START  = 100,
  parameter int Y_GROUND = 440,
  parameter int STEP     = 4,
  parameter int JUMP_V0  = 12,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  output logic [11:0] player_xpos,
  output logic [11:0] player_ypos,
  output State        state,
  output logic        in_air
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } vstate_t;

  localparam logic [12:0] XMIN13  = 13'(X_MIN);
  localparam logic [12:0] XMAX13  = 13'(X_MAX);
  localparam logic [12:0] STEP13  = 13'(STEP);
  localparam logic [12:0] YGND13  = 13'(Y_GROUND);
  localparam logic [8:0]  GRAV9   = 9'(GRAVITY);
  localparam logic [7:0]  GRAV8   = 8'(GRAVITY);
  localparam logic [7:0]  V0      = 8'(JUMP_V0);

  logic [2:0]  btn_s1;
  logic [2:0]  btn_s2;
  logic        vblnk_q;
  logic        tick;
  logic        l;
  logic        r;
  logic        j;

  vstate_t     vst;
  vstate_t     vst_n;
  State        state_n;
  logic [7:0]  vy;
  logic [7:0]  vy_n;
  logic [11:0] x_n;
  logic [11:0] y_n;

  logic [12:0] x13;
  logic [12:0] x_dec;
  logic [12:0] x_inc;
  logic [7:0]  vy_sub;
  logic [8:0]  vy_sum;
  logic [7:0]  vy_add;
  logic [12:0] y_fall;

  assign l      = btn_s2[0];
  assign r      = btn_s2[1];
  assign j      = btn_s2[2];
  assign tick   = vblnk & ~vblnk_q;
  assign in_air = (vst != GROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1      <= '0;
      btn_s2      <= '0;
      vblnk_q     <= 1'b0;
      state       <= IDLE;
      vst         <= GROUND;
      vy          <= '0;
      player_xpos <= 12'(X_START);
      player_ypos <= 12'(Y_GROUND);
    end else begin
      btn_s1      <= {btn_jump, btn_right, btn_left};
      btn_s2      <= btn_s1;
      vblnk_q     <= vblnk;
      state       <= state_n;
      vst         <= vst_n;
      vy          <= vy_n;
      player_xpos <= x_n;
      player_ypos <= y_n;
    end
  end

  // Clamp in 13 bits so a step below X_MIN never wraps.
  always_comb begin
    x13   = {1'b0, player_xpos};
    x_dec = (x13 >= XMIN13 + STEP13) ? x13 - STEP13 : XMIN13;
    x_inc = (x13 + STEP13 > XMAX13) ? XMAX13 : x13 + STEP13;
  end

  always_comb begin
    vy_sub = (vy > GRAV8) ? vy - GRAV8 : 8'd0;
    vy_sum = {1'b0, vy} + GRAV9;
    vy_add = vy_sum[8] ? 8'hff : vy_sum[7:0];
    y_fall = {1'b0, player_ypos} + {5'd0, vy_add};
  end

  always_comb begin
    state_n = state;
    x_n     = player_xpos;
    if (tick) begin
      unique case (1'b1)
        (l & ~r): begin
          state_n = LEFT;
          x_n     = x_dec[11:0];
        end
        (r & ~l): begin
          state_n = RIGHT;
          x_n     = x_inc[11:0];
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    vst_n = vst;
    vy_n  = vy;
    y_n   = player_ypos;
    if (tick) begin
      unique case (vst)
        GROUND: begin
          if (j) begin
            vst_n = RISE;
            vy_n  = V0;
          end
        end
        RISE: begin
          y_n  = player_ypos - {4'd0, vy};
          vy_n = vy_sub;
          if (vy_sub == 8'd0) vst_n = FALL;
        end
        FALL: begin
          if (y_fall >= YGND13) begin
            y_n   = YGND13[11:0];
            vy_n  = 8'd0;
            vst_n = GROUND;
          end else begin
            y_n  = y_fall[11:0];
            vy_n = vy_add;
          end
        end
        default: vst_n = GROUND;
      endcase
    end
  end

endmodule

// File: tb/tb_player_ctl.sv
// Scoreboard bench for player_ctl: stimulus queues expected outputs,
// monitors pop them on each frame tick or reset assertion.
module tb_player_ctl;
  import state_pkg::*;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    State        st;
    logic        air;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        vblnk;
  logic        btn_left;
  logic        btn_right;
  logic        btn_jump;
  logic [11:0] player_xpos;
  logic [11:0] player_ypos;
  State        state;
  logic        in_air;

  exp_t q[$];
  exp_t cur;
  bit   hold_en;
  logic tb_vq;
  int   tests;
  int   fails;

  int rise_y[12] = '{428, 417, 407, 398, 390, 383, 377, 372, 368, 365, 363, 362};
  int fall_y[12] = '{363, 365, 368, 372, 377, 383, 390, 398, 407, 417, 428, 440};

  player_ctl dut (
    .clk(clk),
    .rst_n(rst_n),
    .vblnk(vblnk),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_jump(btn_jump),
    .player_xpos(player_xpos),
    .player_ypos(player_ypos),
    .state(state),
    .in_air(in_air)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(int x, int y, State st, logic air);
    exp_t e;
    e.x   = 12'(x);
    e.y   = 12'(y);
    e.st  = st;
    e.air = air;
    return e;
  endfunction

  task automatic compare(input string nm, input exp_t e);
    tests++;
    if (player_xpos !== e.x || player_ypos !== e.y ||
        state !== e.st || in_air !== e.air) begin
      fails++;
      $display("FAIL %s @%0t: got x=%0d y=%0d st=%0d air=%b, want x=%0d y=%0d st=%0d air=%b",
               nm, $time, player_xpos, player_ypos, state, in_air,
               e.x, e.y, e.st, e.air);
    end
  endtask

  task automatic pop_check(input string nm);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL %s @%0t: unexpected update, scoreboard empty", nm, $time);
    end else begin
      tests--;
      e = q.pop_front();
      compare(nm, e);
      cur = e;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_vq <= 1'b0;
    else        tb_vq <= vblnk;
  end

  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      pop_check("reset");
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && vblnk && !tb_vq) begin
        #1;
        pop_check("tick");
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && hold_en) compare("hold", cur);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic frame(input logic bl, input logic br, input logic bj,
                       input exp_t e);
    btn_left  = bl;
    btn_right = br;
    btn_jump  = bj;
    repeat (3) @(posedge clk);
    #2;
    q.push_back(e);
    vblnk = 1'b1;
    @(posedge clk);
    #2;
    vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int x;
    tests     = 0;
    fails     = 0;
    hold_en   = 1'b0;
    rst_n     = 1'b1;
    vblnk     = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_jump  = 1'b0;
    q.push_back(mk(100, 440, IDLE, 1'b0));
    #2 rst_n = 1'b0;
    #20;
    hold_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    frame(0, 0, 0, mk(100, 440, IDLE, 0));
    frame(0, 1, 0, mk(104, 440, RIGHT, 0));
    frame(0, 1, 0, mk(108, 440, RIGHT, 0));
    frame(0, 1, 0, mk(112, 440, RIGHT, 0));
    frame(0, 0, 0, mk(112, 440, IDLE, 0));
    frame(1, 1, 0, mk(112, 440, IDLE, 0));
    frame(1, 1, 0, mk(112, 440, IDLE, 0));

    x = 112;
    for (int k = 0; k < 28; k++) begin
      x -= 4;
      frame(1, 0, 0, mk(x, 440, LEFT, 0));
    end
    frame(1, 0, 0, mk(0, 440, LEFT, 0));

    for (int k = 0; k < 246; k++) begin
      x += 4;
      frame(0, 1, 0, mk(x, 440, RIGHT, 0));
    end
    frame(0, 1, 0, mk(984, 440, RIGHT, 0));
    frame(0, 0, 0, mk(984, 440, IDLE, 0));

    x = 980;
    frame(1, 0, 1, mk(x, 440, LEFT, 1));
    for (int k = 0; k < 24; k++) begin
      x -= 4;
      if (k < 12) frame(1, 0, 0, mk(x, rise_y[k], LEFT, 1));
      else        frame(1, 0, 0, mk(x, fall_y[k-12], LEFT, k != 23));
    end

    frame(0, 0, 1, mk(x, 440, IDLE, 1));
    for (int k = 0; k < 24; k++) begin
      if (k < 12) frame(0, 0, 1, mk(x, rise_y[k], IDLE, 1));
      else        frame(0, 0, 1, mk(x, fall_y[k-12], IDLE, k != 23));
    end
    frame(0, 0, 1, mk(x, 440, IDLE, 1));
    for (int k = 0; k < 6; k++)
      frame(0, 0, 0, mk(x, rise_y[k], IDLE, 1));

    q.push_back(mk(100, 440, IDLE, 0));
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    btn_right = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    q.push_back(mk(104, 440, RIGHT, 0));
    vblnk = 1'b1;
    repeat (80) @(posedge clk);
    #2 vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    frame(0, 0, 0, mk(104, 440, IDLE, 0));
    btn_left = 1'b1;
    btn_jump = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    btn_left = 1'b0;
    btn_jump = 1'b0;

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
